// File: rtl/mux_rr_arbiter_if.sv
// Request/grant/select bundle between the four mux requesters and the arbiter.
interface mux_rr_arbiter_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       s1;
    logic       s2;
    logic       busy;

    modport master (output req, input gnt, s1, s2, busy);
    modport slave  (input req, output gnt, s1, s2, busy);
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the 4:1 mux selects, with bounded tenure per grant.
//   state | meaning
//   IDLE  | no grant; selects hold their last value
//   GRANT | one requester owns F; released on req drop or hold limit
module mux_rr_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst,
    mux_rr_arbiter_if.slave   bus
);
    localparam int CW = $clog2(MAX_HOLD + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state;
    logic [1:0]    last;
    logic [CW-1:0] hold_cnt;
    logic [3:0]    gnt;
    logic          s1;
    logic          s2;
    logic          busy;

    logic [1:0]    win;
    logic [1:0]    cand;
    logic          release_now;

    // Scan from lowest to highest priority so the highest-priority hit is written last.
    always_comb begin
        win  = last;
        cand = last;
        for (int k = 4; k >= 1; k--) begin
            cand = last + 2'(k);
            if (bus.req[cand]) win = cand;
        end
    end

    assign release_now = !bus.req[last] || (hold_cnt == CW'(MAX_HOLD));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last     <= 2'd3;
            hold_cnt <= '0;
            gnt      <= 4'b0000;
            s1       <= 1'b0;
            s2       <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        state    <= GRANT;
                        last     <= win;
                        hold_cnt <= CW'(1);
                        gnt      <= 4'b0001 << win;
                        s1       <= win[1];
                        s2       <= win[0];
                        busy     <= 1'b1;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        if (|bus.req) begin
                            // Covers both handoff and re-grant of a lone timed-out owner.
                            last     <= win;
                            hold_cnt <= CW'(1);
                            gnt      <= 4'b0001 << win;
                            s1       <= win[1];
                            s2       <= win[0];
                        end else begin
                            state    <= IDLE;
                            hold_cnt <= '0;
                            gnt      <= 4'b0000;
                            busy     <= 1'b0;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt  = gnt;
    assign bus.s1   = s1;
    assign bus.s2   = s2;
    assign bus.busy = busy;
endmodule
